// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared register offsets and sizing constants for irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    localparam int IC_NSRC_MAX      = 8;
    // Index must also encode "none found" (== number of sources)
    localparam int IC_IDX_W         = $clog2(IC_NSRC_MAX + 1);
    localparam int IC_VEC_VALID_BIT = 31;

    localparam int IC_REG_MASK  = 0;
    localparam int IC_REG_MODE  = 1;
    localparam int IC_REG_PEND  = 2;
    localparam int IC_REG_INSVC = 3;
    localparam int IC_REG_VEC   = 4;
    localparam int IC_REG_ACK   = 5;
    localparam int IC_REG_EOI   = 6;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Lowest-set-bit encoder; idx_o = W and found_o = 0 when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0]        req_i,
    output logic [IC_IDX_W-1:0] idx_o,
    output logic                found_o
);

    always_comb begin
        idx_o   = IC_IDX_W'(W);
        found_o = 1'b0;
        // Scan downward so the lowest set index is the last one written
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IC_IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Fixed-priority nesting interrupt controller with mask, edge/
//               level mode, pending/in-service tracking and ACK/EOI registers.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 6,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AW-1:0]    add_i,
    input  logic             we_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    input  logic [N_SRC-1:0] src_i,
    output logic             irq_o
);

    logic [N_SRC-1:0]    r_sync1, r_sync2, r_prev;
    logic [N_SRC-1:0]    r_mask, r_mode, r_pend, r_insvc;
    logic [N_SRC-1:0]    w_rise, w_elig, w_clr, w_ack_set, w_eoi_clr;
    logic [N_SRC-1:0]    w_pend_next, w_insvc_next, w_cand_oh, w_cur_oh;
    logic [IC_IDX_W-1:0] w_cand, w_cur;
    logic                w_cand_found, w_cur_found, w_valid;
    logic                w_wr_mask, w_wr_mode, w_wr_pend, w_ack, w_eoi;
    logic [31:0]         w_rdata;
    logic                w_unused_dat;

    assign w_unused_dat = ^dat_i[31:N_SRC];

    assign w_wr_mask = we_i && (add_i == AW'(IC_REG_MASK));
    assign w_wr_mode = we_i && (add_i == AW'(IC_REG_MODE));
    assign w_wr_pend = we_i && (add_i == AW'(IC_REG_PEND));
    assign w_ack     = we_i && (add_i == AW'(IC_REG_ACK)) && w_valid;
    assign w_eoi     = we_i && (add_i == AW'(IC_REG_EOI)) && w_cur_found;

    assign w_rise = r_sync2 & ~r_prev;
    assign w_elig = r_pend & r_mask;

    irq_prio_enc #(.W(N_SRC)) u_cand_enc (
        .req_i   (w_elig),
        .idx_o   (w_cand),
        .found_o (w_cand_found)
    );

    irq_prio_enc #(.W(N_SRC)) u_cur_enc (
        .req_i   (r_insvc),
        .idx_o   (w_cur),
        .found_o (w_cur_found)
    );

    // Only a strictly higher-priority source may preempt the active handler
    assign w_valid = w_cand_found && (w_cand < w_cur);

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            assign w_cand_oh[i]    = (w_cand == IC_IDX_W'(i));
            assign w_cur_oh[i]     = (w_cur == IC_IDX_W'(i));
            assign w_ack_set[i]    = w_ack & w_cand_oh[i];
            assign w_eoi_clr[i]    = w_eoi & w_cur_oh[i];
            assign w_clr[i]        = (w_wr_pend & dat_i[i]) | w_ack_set[i];
            // Edge: a new edge beats a simultaneous clear. Level: follow input.
            assign w_pend_next[i]  = r_mode[i] ? ((r_pend[i] & ~w_clr[i]) | w_rise[i])
                                               : r_sync2[i];
            assign w_insvc_next[i] = (r_insvc[i] | w_ack_set[i]) & ~w_eoi_clr[i];
        end
    endgenerate

    always_comb begin
        w_rdata = 32'd0;
        case (add_i)
            AW'(IC_REG_MASK):  w_rdata = {{(32 - N_SRC){1'b0}}, r_mask};
            AW'(IC_REG_MODE):  w_rdata = {{(32 - N_SRC){1'b0}}, r_mode};
            AW'(IC_REG_PEND):  w_rdata = {{(32 - N_SRC){1'b0}}, r_pend};
            AW'(IC_REG_INSVC): w_rdata = {{(32 - N_SRC){1'b0}}, r_insvc};
            AW'(IC_REG_VEC): begin
                w_rdata[IC_VEC_VALID_BIT] = w_valid;
                w_rdata[7:0]              = {{(8 - IC_IDX_W){1'b0}}, w_cand};
            end
            default:           w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_mask  <= '0;
            r_mode  <= '1;
            r_pend  <= '0;
            r_insvc <= '0;
            dat_o   <= 32'd0;
            irq_o   <= 1'b0;
        end else begin
            r_sync1 <= src_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_wr_mask) r_mask <= dat_i[N_SRC-1:0];
            if (w_wr_mode) r_mode <= dat_i[N_SRC-1:0];
            r_pend  <= w_pend_next;
            r_insvc <= w_insvc_next;
            dat_o   <= w_rdata;
            irq_o   <= w_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Self-checking bench for irq_ctrl using a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int N_SRC = 6;
    localparam int AW    = 3;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [AW-1:0]    add_i;
    logic             we_i;
    logic [31:0]      dat_i;
    logic [31:0]      dat_o;
    logic [N_SRC-1:0] src_i;
    logic             irq_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q_exp[$];

    irq_ctrl #(.N_SRC(N_SRC), .AW(AW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .add_i (add_i),
        .we_i  (we_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .src_i (src_i),
        .irq_o (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string tag);
        add_i = AW'(a);
        we_i  = 1'b0;
        q_exp.push_back(exp);
        idle(1);
        check(tag, dat_o, q_exp.pop_front());
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        add_i = AW'(a);
        dat_i = d;
        we_i  = 1'b1;
        idle(1);
        we_i  = 1'b0;
        dat_i = 32'd0;
    endtask

    // Rising edge on src i, held one clock; PEND sets on the third edge
    task automatic pulse(input int i);
        src_i[i] = 1'b1;
        idle(1);
        src_i[i] = 1'b0;
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        add_i = '0;
        we_i  = 1'b0;
        dat_i = 32'd0;
        src_i = '0;
        #23;
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        rd(IC_REG_MASK, 32'h0, "mask_rst");
        rd(IC_REG_MODE, 32'h3F, "mode_rst");
        wr(IC_REG_MASK, 32'hFFFF_FFFF);
        rd(IC_REG_MASK, 32'h3F, "mask_wr");

        // Basic edge request: latency 3 clocks to PEND, 1 more to irq_o
        src_i[2] = 1'b1;
        idle(1);
        src_i[2] = 1'b0;
        rd(IC_REG_PEND, 32'h00, "pend_lat1");
        rd(IC_REG_PEND, 32'h00, "pend_lat2");
        check("irq_early", {31'd0, irq_o}, 32'd0);
        rd(IC_REG_PEND, 32'h04, "pend_set");
        check("irq_set", {31'd0, irq_o}, 32'd1);
        rd(IC_REG_VEC, 32'h8000_0002, "vec_2");
        wr(IC_REG_ACK, 32'd0);
        rd(IC_REG_INSVC, 32'h04, "insvc_ack");
        check("irq_ack", {31'd0, irq_o}, 32'd0);
        rd(IC_REG_PEND, 32'h00, "pend_ack");
        wr(IC_REG_EOI, 32'd0);
        rd(IC_REG_INSVC, 32'h00, "insvc_eoi");
        rd(IC_REG_ACK, 32'h0, "rd_ack_zero");
        wr(7, 32'hFFFF_FFFF);
        rd(7, 32'h0, "rd_unused");

        // Nesting
        pulse(3);
        wr(IC_REG_ACK, 32'd0);
        pulse(1);
        idle(1);
        check("nest_irq1", {31'd0, irq_o}, 32'd1);
        rd(IC_REG_VEC, 32'h8000_0001, "vec_1");
        wr(IC_REG_ACK, 32'd0);
        rd(IC_REG_INSVC, 32'h0A, "insvc_nest");
        pulse(5);
        idle(1);
        check("nest_irq5", {31'd0, irq_o}, 32'd0);
        rd(IC_REG_VEC, 32'h0000_0005, "vec_5_blk");
        wr(IC_REG_EOI, 32'd0);
        idle(1);
        check("eoi1_irq", {31'd0, irq_o}, 32'd0);
        rd(IC_REG_INSVC, 32'h08, "insvc_eoi1");
        wr(IC_REG_EOI, 32'd0);
        idle(1);
        check("eoi3_irq", {31'd0, irq_o}, 32'd1);
        rd(IC_REG_VEC, 32'h8000_0005, "vec_5");
        wr(IC_REG_ACK, 32'd0);
        wr(IC_REG_EOI, 32'd0);
        rd(IC_REG_INSVC, 32'h00, "insvc_clean");
        rd(IC_REG_PEND, 32'h00, "pend_clean");

        // Level mode on source 0
        wr(IC_REG_MODE, 32'h3E);
        src_i[0] = 1'b1;
        idle(3);
        rd(IC_REG_PEND, 32'h01, "lvl_set");
        wr(IC_REG_PEND, 32'h01);
        rd(IC_REG_PEND, 32'h01, "lvl_w1c");
        wr(IC_REG_ACK, 32'd0);
        rd(IC_REG_PEND, 32'h01, "lvl_ack_pend");
        rd(IC_REG_INSVC, 32'h01, "lvl_ack_insvc");
        wr(IC_REG_EOI, 32'd0);
        src_i[0] = 1'b0;
        idle(3);
        rd(IC_REG_PEND, 32'h00, "lvl_drop");
        wr(IC_REG_MODE, 32'h3F);

        // Edge set wins over a simultaneous W1C
        pulse(4);
        src_i[4] = 1'b1;
        idle(2);
        wr(IC_REG_PEND, 32'h10);
        src_i[4] = 1'b0;
        rd(IC_REG_PEND, 32'h10, "set_wins");
        wr(IC_REG_PEND, 32'h10);
        rd(IC_REG_PEND, 32'h00, "w1c_edge");

        // ACK with no valid request changes nothing
        pulse(2);
        wr(IC_REG_ACK, 32'd0);
        wr(IC_REG_ACK, 32'd0);
        rd(IC_REG_INSVC, 32'h04, "ack_nop_insvc");
        rd(IC_REG_PEND, 32'h00, "ack_nop_pend");
        wr(IC_REG_EOI, 32'd0);

        // Masked source stays pending but does not request
        wr(IC_REG_MASK, 32'h3D);
        pulse(1);
        idle(1);
        check("mask_irq", {31'd0, irq_o}, 32'd0);
        rd(IC_REG_VEC, 32'h0000_0006, "vec_masked");
        wr(IC_REG_PEND, 32'h02);
        wr(IC_REG_MASK, 32'h3F);

        // Asynchronous reset while active
        pulse(3);
        wr(IC_REG_ACK, 32'd0);
        pulse(1);
        idle(1);
        check("pre_rst_irq", {31'd0, irq_o}, 32'd1);
        rd(IC_REG_INSVC, 32'h08, "pre_rst_insvc");
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_irq", {31'd0, irq_o}, 32'd0);
        check("arst_dat", dat_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd(IC_REG_PEND, 32'h00, "arst_pend");
        rd(IC_REG_INSVC, 32'h00, "arst_insvc");
        rd(IC_REG_MASK, 32'h00, "arst_mask");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
